// File: rtl/trap_ctrl_pkg.sv
// Shared trap-channel definitions: CSR addresses, mcause codes, state and event encodings.
// Build option TRAP_MTVAL_EN (define on the command line) adds the mtval write state.
package trap_ctrl_pkg;

  localparam int RegBus     = 32;
  localparam int CsrAddrBus = 12;

  localparam logic [CsrAddrBus-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CsrAddrBus-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CsrAddrBus-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CsrAddrBus-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CsrAddrBus-1:0] CSR_MTVAL   = 12'h343;

  localparam logic [RegBus-1:0] MCAUSE_ILLEGAL = 32'd2;
  localparam logic [RegBus-1:0] MCAUSE_EBREAK  = 32'd3;
  localparam logic [RegBus-1:0] MCAUSE_ECALL   = 32'd11;
  localparam logic [RegBus-1:0] MCAUSE_MSI     = 32'h8000_0003;
  localparam logic [RegBus-1:0] MCAUSE_MTI     = 32'h8000_0007;
  localparam logic [RegBus-1:0] MCAUSE_MEI     = 32'h8000_000B;

  typedef enum logic [2:0] {
    S_IDLE, S_W_MEPC, S_W_MCAUSE, S_W_MTVAL, S_W_MSTATUS, S_R_MSTATUS, S_JUMP
  } state_t;

  typedef enum logic [1:0] {K_NONE, K_EXC, K_INT, K_MRET} kind_t;

endpackage

// File: rtl/trap_ctrl_prio.sv
// Purely combinational priority encoder: illegal > ecall > ebreak > mret > MEI > MSI > MTI.
// Interrupts only qualify while the global interrupt enable is set.
module trap_prio
  import trap_ctrl_pkg::*;
(
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        illegal,
  input  logic        mret,
  input  logic        ext_irq,
  input  logic        tcmp_irq,
  input  logic        soft_irq,
  input  logic        mie,
  output logic        take,
  output logic [1:0]  kind,
  output logic [31:0] mcause
);

  always_comb begin
    take   = 1'b1;
    kind   = K_EXC;
    mcause = '0;
    if (illegal)               mcause = MCAUSE_ILLEGAL;
    else if (ecall)            mcause = MCAUSE_ECALL;
    else if (ebreak)           mcause = MCAUSE_EBREAK;
    else if (mret)             kind   = K_MRET;
    else if (mie && ext_irq) begin
      kind   = K_INT;
      mcause = MCAUSE_MEI;
    end else if (mie && soft_irq) begin
      kind   = K_INT;
      mcause = MCAUSE_MSI;
    end else if (mie && tcmp_irq) begin
      kind   = K_INT;
      mcause = MCAUSE_MTI;
    end else begin
      take = 1'b0;
      kind = K_NONE;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: writes mepc/mcause/(mtval)/mstatus on trap entry, mstatus on mret, then redirects.
// Latency: trap jump at N+5 (N+4 without TRAP_MTVAL_EN), mret jump at N+2; hold_o stalls the pipeline throughout.
// No backpressure on the trap channel: idex CSR writes must be held off while hold_o is high.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ecall_i,
  input  logic                  ebreak_i,
  input  logic                  illegal_i,
  input  logic                  mret_i,
  input  logic                  hx_valid_i,
  input  logic [RegBus-1:0]     inst_i,
  input  logic [RegBus-1:0]     inst_pc_i,
  input  logic [RegBus-1:0]     next_pc_i,
  input  logic                  ex_trap_valid_i,
  input  logic                  tcmp_trap_valid_i,
  input  logic                  soft_trap_valid_i,
  input  logic                  mstatus_MIE3_i,
  input  logic [RegBus-1:0]     mepc_i,
  output logic                  trap_csr_we_o,
  output logic [CsrAddrBus-1:0] trap_csr_addr_o,
  output logic [RegBus-1:0]     trap_csr_wdata_o,
  input  logic [RegBus-1:0]     trap_csr_rdata_i,
  output logic                  hold_o,
  output logic                  jump_o,
  output logic [RegBus-1:0]     jump_addr_o
);

  state_t            state, state_d;
  kind_t             kind_q;
  logic [RegBus-1:0] mcause_q, mepc_q;
  logic              take;
  logic [1:0]        kind_raw;
  logic [RegBus-1:0] mcause_raw;
  logic              accept;

  trap_prio u_prio (
    .ecall    (ecall_i),
    .ebreak   (ebreak_i),
    .illegal  (illegal_i),
    .mret     (mret_i),
    .ext_irq  (ex_trap_valid_i),
    .tcmp_irq (tcmp_trap_valid_i),
    .soft_irq (soft_trap_valid_i),
    .mie      (mstatus_MIE3_i),
    .take     (take),
    .kind     (kind_raw),
    .mcause   (mcause_raw)
  );

  assign accept = (state == S_IDLE) && hx_valid_i && take;

`ifdef TRAP_MTVAL_EN
  logic [RegBus-1:0] mtval_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtval_q <= '0;
    end else if (accept) begin
      case (mcause_raw)
        MCAUSE_ILLEGAL: mtval_q <= inst_i;
        MCAUSE_EBREAK:  mtval_q <= inst_pc_i;
        default:        mtval_q <= '0;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      kind_q   <= K_NONE;
      mcause_q <= '0;
      mepc_q   <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        kind_q   <= kind_t'(kind_raw);
        mcause_q <= mcause_raw;
        mepc_q   <= (kind_t'(kind_raw) == K_INT) ? next_pc_i : inst_pc_i;
      end
    end
  end

  always_comb begin
    state_d          = state;
    trap_csr_we_o    = 1'b0;
    trap_csr_addr_o  = '0;
    trap_csr_wdata_o = '0;
    jump_o           = 1'b0;
    jump_addr_o      = '0;
    hold_o           = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (accept) begin
          hold_o  = 1'b1;
          state_d = (kind_t'(kind_raw) == K_MRET) ? S_R_MSTATUS : S_W_MEPC;
        end
      end
      S_W_MEPC: begin
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MEPC;
        trap_csr_wdata_o = mepc_q;
        state_d          = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MCAUSE;
        trap_csr_wdata_o = mcause_q;
`ifdef TRAP_MTVAL_EN
        state_d          = S_W_MTVAL;
`else
        state_d          = S_W_MSTATUS;
`endif
      end
`ifdef TRAP_MTVAL_EN
      S_W_MTVAL: begin
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MTVAL;
        trap_csr_wdata_o = mtval_q;
        state_d          = S_W_MSTATUS;
      end
`endif
      // MPIE <= MIE, MIE <= 0
      S_W_MSTATUS: begin
        trap_csr_we_o       = 1'b1;
        trap_csr_addr_o     = CSR_MSTATUS;
        trap_csr_wdata_o[7] = trap_csr_rdata_i[3];
        state_d             = S_JUMP;
      end
      // MIE <= MPIE, MPIE <= 1
      S_R_MSTATUS: begin
        trap_csr_we_o       = 1'b1;
        trap_csr_addr_o     = CSR_MSTATUS;
        trap_csr_wdata_o[3] = trap_csr_rdata_i[7];
        trap_csr_wdata_o[7] = 1'b1;
        state_d             = S_JUMP;
      end
      S_JUMP: begin
        jump_o  = 1'b1;
        state_d = S_IDLE;
        if (kind_q == K_MRET) begin
          jump_addr_o = mepc_i;
        end else begin
          trap_csr_addr_o = CSR_MTVEC;
          jump_addr_o     = {trap_csr_rdata_i[31:2], 2'b00};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: CSR file model, write scoreboard, per-scenario timing checks.
// Honours TRAP_MTVAL_EN the same way as the design build.
module tb_trap_ctrl;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;
`ifdef TRAP_MTVAL_EN
  localparam int JUMP_AT = 5;
`else
  localparam int JUMP_AT = 4;
`endif

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ecall_i, ebreak_i, illegal_i, mret_i, hx_valid_i;
  logic [31:0] inst_i, inst_pc_i, next_pc_i, mepc_i;
  logic        ex_trap_valid_i, tcmp_trap_valid_i, soft_trap_valid_i, mstatus_MIE3_i;
  logic        trap_csr_we_o;
  logic [11:0] trap_csr_addr_o;
  logic [31:0] trap_csr_wdata_o, trap_csr_rdata_i;
  logic        hold_o, jump_o;
  logic [31:0] jump_addr_o;

  logic [31:0] mstatus_r, mtvec_r;
  wr_t         exp_q[$];
  wr_t         exp_e;
  int          compared   = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ecall_i           (ecall_i),
    .ebreak_i          (ebreak_i),
    .illegal_i         (illegal_i),
    .mret_i            (mret_i),
    .hx_valid_i        (hx_valid_i),
    .inst_i            (inst_i),
    .inst_pc_i         (inst_pc_i),
    .next_pc_i         (next_pc_i),
    .ex_trap_valid_i   (ex_trap_valid_i),
    .tcmp_trap_valid_i (tcmp_trap_valid_i),
    .soft_trap_valid_i (soft_trap_valid_i),
    .mstatus_MIE3_i    (mstatus_MIE3_i),
    .mepc_i            (mepc_i),
    .trap_csr_we_o     (trap_csr_we_o),
    .trap_csr_addr_o   (trap_csr_addr_o),
    .trap_csr_wdata_o  (trap_csr_wdata_o),
    .trap_csr_rdata_i  (trap_csr_rdata_i),
    .hold_o            (hold_o),
    .jump_o            (jump_o),
    .jump_addr_o       (jump_addr_o)
  );

  // Minimal CSR file: asynchronous read, write on the clock edge.
  always_comb begin
    trap_csr_rdata_i = 32'h0;
    if (trap_csr_addr_o == A_MSTATUS)    trap_csr_rdata_i = mstatus_r;
    else if (trap_csr_addr_o == A_MTVEC) trap_csr_rdata_i = mtvec_r;
  end

  always @(posedge clk) begin
    if (rst_n && trap_csr_we_o && trap_csr_addr_o == A_MSTATUS) mstatus_r <= trap_csr_wdata_o;
  end

  // Scoreboard: every trap-channel write must match the next expected write in order.
  always @(negedge clk) begin
    if (rst_n && trap_csr_we_o) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", trap_csr_addr_o, trap_csr_wdata_o);
      end else begin
        exp_e = exp_q.pop_front();
        if ({trap_csr_addr_o, trap_csr_wdata_o} !== {exp_e.addr, exp_e.data}) begin
          mismatched++;
          $display("FAIL csr_write: got addr=%h data=%h, expected addr=%h data=%h",
                   trap_csr_addr_o, trap_csr_wdata_o, exp_e.addr, exp_e.data);
        end
      end
    end
  end

  task automatic clear_inputs();
    hx_valid_i = 0; ecall_i = 0; ebreak_i = 0; illegal_i = 0; mret_i = 0;
    ex_trap_valid_i = 0; tcmp_trap_valid_i = 0; soft_trap_valid_i = 0;
  endtask

  task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause,
                           input logic [31:0] tval, input logic [31:0] mst);
    exp_q.push_back({A_MEPC, epc});
    exp_q.push_back({A_MCAUSE, cause});
`ifdef TRAP_MTVAL_EN
    exp_q.push_back({A_MTVAL, tval});
`else
    if (tval !== tval) exp_q.push_back({A_MTVAL, tval});
`endif
    exp_q.push_back({A_MSTATUS, mst});
  endtask

  task automatic test_reset();
    #2;
    compared++;
    if ({trap_csr_we_o, trap_csr_addr_o, trap_csr_wdata_o, hold_o, jump_o, jump_addr_o} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got we=%b addr=%h wdata=%h hold=%b jump=%b jaddr=%h, expected all 0",
               trap_csr_we_o, trap_csr_addr_o, trap_csr_wdata_o, hold_o, jump_o, jump_addr_o);
    end
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    compared++;
    if ({trap_csr_we_o, hold_o, jump_o} !== 3'b000) begin
      mismatched++;
      $display("FAIL post_reset_idle: got we=%b hold=%b jump=%b, expected 0 0 0", trap_csr_we_o, hold_o, jump_o);
    end
  endtask

  // Runs one trap sequence; keep_req holds the request asserted until JUMP to prove it is ignored.
  task automatic run_trap(input string name, input logic [31:0] exp_jaddr, input bit keep_req);
    for (int k = 0; k <= JUMP_AT + 1; k++) begin
      @(negedge clk);
      compared++;
      if (hold_o !== (k <= JUMP_AT) || jump_o !== (k == JUMP_AT)) begin
        mismatched++;
        $display("FAIL %s_timing cycle N+%0d: got hold=%b jump=%b, expected hold=%b jump=%b",
                 name, k, hold_o, jump_o, k <= JUMP_AT, k == JUMP_AT);
      end
      if (k == JUMP_AT) begin
        compared++;
        if (jump_addr_o !== exp_jaddr) begin
          mismatched++;
          $display("FAIL %s_jump_addr: got %h, expected %h", name, jump_addr_o, exp_jaddr);
        end
      end
      @(posedge clk); #1;
      if (!keep_req || k >= JUMP_AT) clear_inputs();
    end
  endtask

  task automatic test_ecall();
    mstatus_r = 32'h8; mtvec_r = 32'h2001;
    push_trap(32'h100, 32'd11, 32'h0, 32'h80);
    @(posedge clk); #1;
    hx_valid_i = 1; ecall_i = 1; inst_pc_i = 32'h100; inst_i = 32'h0000_0073;
    run_trap("ecall", 32'h2000, 0);
  endtask

  task automatic test_illegal();
    mstatus_r = 32'h0; mtvec_r = 32'h2001;
    push_trap(32'h40, 32'd2, 32'hFFFF_FFFF, 32'h0);
    @(posedge clk); #1;
    hx_valid_i = 1; illegal_i = 1; inst_pc_i = 32'h40; inst_i = 32'hFFFF_FFFF;
    run_trap("illegal", 32'h2000, 1);
  endtask

  task automatic test_irq_priority();
    mstatus_r = 32'h8; mtvec_r = 32'h0000_3000;
    push_trap(32'h84, 32'h8000_000B, 32'h0, 32'h80);
    @(posedge clk); #1;
    hx_valid_i = 1; mstatus_MIE3_i = 1; ex_trap_valid_i = 1; tcmp_trap_valid_i = 1;
    inst_pc_i = 32'h80; next_pc_i = 32'h84;
    run_trap("irq_mei", 32'h3000, 0);
  endtask

  task automatic test_irq_masked();
    @(posedge clk); #1;
    mstatus_MIE3_i = 0; hx_valid_i = 1;
    ex_trap_valid_i = 1; tcmp_trap_valid_i = 1; soft_trap_valid_i = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      compared++;
      if (hold_o !== 1'b0 || trap_csr_we_o !== 1'b0) begin
        mismatched++;
        $display("FAIL irq_masked cycle %0d: got hold=%b we=%b, expected 0 0", k, hold_o, trap_csr_we_o);
      end
    end
    @(posedge clk); #1 clear_inputs();
  endtask

  task automatic test_irq_ebreak();
    mstatus_r = 32'h8; mtvec_r = 32'h2001;
    push_trap(32'h60, 32'd3, 32'h60, 32'h80);
    @(posedge clk); #1;
    hx_valid_i = 1; mstatus_MIE3_i = 1; tcmp_trap_valid_i = 1; ebreak_i = 1;
    inst_pc_i = 32'h60; next_pc_i = 32'h64;
    run_trap("ebreak_irq", 32'h2000, 0);
    mstatus_MIE3_i = 0;
  endtask

  task automatic test_mret();
    mstatus_r = 32'h80;
    exp_q.push_back({A_MSTATUS, 32'h88});
    @(posedge clk); #1;
    hx_valid_i = 1; mret_i = 1; mepc_i = 32'h84;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      compared++;
      if (hold_o !== (k <= 2) || jump_o !== (k == 2)) begin
        mismatched++;
        $display("FAIL mret_timing cycle N+%0d: got hold=%b jump=%b, expected hold=%b jump=%b",
                 k, hold_o, jump_o, k <= 2, k == 2);
      end
      if (k == 2) begin
        compared++;
        if (jump_addr_o !== 32'h84 || trap_csr_we_o !== 1'b0) begin
          mismatched++;
          $display("FAIL mret_jump: got jaddr=%h we=%b, expected 00000084 0", jump_addr_o, trap_csr_we_o);
        end
      end
      @(posedge clk); #1 clear_inputs();
    end
  endtask

  task automatic test_reset_mid();
    mstatus_r = 32'h8; mtvec_r = 32'h2001;
    exp_q.push_back({A_MEPC, 32'h100});
    @(posedge clk); #1;
    hx_valid_i = 1; ecall_i = 1; inst_pc_i = 32'h100;
    @(posedge clk); #1 clear_inputs();
    @(posedge clk); #1 rst_n = 0;
    #1;
    compared++;
    if ({trap_csr_we_o, trap_csr_addr_o, trap_csr_wdata_o, hold_o, jump_o, jump_addr_o} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid: got we=%b addr=%h wdata=%h hold=%b jump=%b, expected all 0",
               trap_csr_we_o, trap_csr_addr_o, trap_csr_wdata_o, hold_o, jump_o);
    end
    @(posedge clk); #1 rst_n = 1;
    test_ecall();
  endtask

  initial begin
    rst_n = 0; clear_inputs();
    inst_i = 0; inst_pc_i = 0; next_pc_i = 0; mepc_i = 0; mstatus_MIE3_i = 0;
    mstatus_r = 0; mtvec_r = 0;
    test_reset();
    test_ecall();
    test_illegal();
    test_irq_priority();
    test_irq_masked();
    test_irq_ebreak();
    test_mret();
    test_reset_mid();
    repeat (2) @(posedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL missing_writes: got %0d expected writes never seen, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer for the SparrowRV core. It drives the trap channel of the CSR register file on trap entry and `mret`. On an exception, an accepted interrupt or an `mret`, it stalls the pipeline and writes mepc, mcause, mtval and mstatus as one fixed cycle sequence. It then issues a one-cycle redirect to the mtvec handler or back to mepc.

## Interface
- Parameters: none. Widths come from `RegBus` (32) and `CsrAddrBus` (12) in the shared defines.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ecall_i` / `ebreak_i` / `illegal_i` in 1 each: synchronous exception from execute, valid with `hx_valid_i`.
- `mret_i` in 1: mret executing, valid with `hx_valid_i`.
- `hx_valid_i` in 1: instruction write-back/retire valid.
- `inst_i` in 32: current instruction word.
- `inst_pc_i` in 32: PC of the current instruction.
- `next_pc_i` in 32: PC of the next instruction to execute.
- `ex_trap_valid_i` / `tcmp_trap_valid_i` / `soft_trap_valid_i` in 1 each: masked interrupt requests from csr.
- `mstatus_MIE3_i` in 1: global interrupt enable.
- `mepc_i` in 32: direct mepc value, used as the mret target.
- `trap_csr_we_o` out 1: write enable for the trap channel.
- `trap_csr_addr_o` out 12: CSR address.
- `trap_csr_wdata_o` out 32: CSR write data.
- `trap_csr_rdata_i` in 32: asynchronous read data for `trap_csr_addr_o`.
- `hold_o` out 1: pipeline stall.
- `jump_o` out 1: one-cycle redirect pulse.
- `jump_addr_o` out 32: redirect target, valid while `jump_o` is high.

## Operation
- States:
  - Trap path: IDLE → W_MEPC → W_MCAUSE → W_MTVAL → W_MSTATUS → JUMP → IDLE.
  - mret path: IDLE → R_MSTATUS → JUMP → IDLE.
- Request acceptance: requests are taken only in IDLE, in a cycle where `hx_valid_i` = 1. Requests arriving in any other state are ignored.
- Priority: illegal > ecall > ebreak > mret > MEI > MSI > MTI.
- Interrupts are taken only when `mstatus_MIE3_i` = 1.
- On acceptance, the following are latched:
  - mcause.
  - mepc value: `inst_pc_i` for exceptions, `next_pc_i` for interrupts.
  - mtval value: `inst_i` for illegal, `inst_pc_i` for ebreak, 0 otherwise.
  - Event kind.
- mcause codes:
  - illegal = 2, ebreak = 3, ecall = 11.
  - MSI = 0x8000_0003, MTI = 0x8000_0007, MEI = 0x8000_000B.
- W_MEPC, W_MCAUSE, W_MTVAL: `trap_csr_we_o` = 1, address `CSR_MEPC` / `CSR_MCAUSE` / `CSR_MTVAL`, data is the latched value.
- W_MSTATUS: address `CSR_MSTATUS`, we = 1. wdata is built from rdata r: bit 7 = r[3], bit 3 = 0, all other bits 0.
- R_MSTATUS (mret): address `CSR_MSTATUS`, we = 1. wdata: bit 3 = r[7], bit 7 = 1.
- JUMP: `jump_o` = 1, we = 0.
  - Trap path: address `CSR_MTVEC`, `jump_addr_o` = {r[31:2], 2'b00}.
  - mret path: `jump_addr_o` = `mepc_i`.
- Outside the write states, `trap_csr_we_o`, `trap_csr_addr_o` and `trap_csr_wdata_o` are all 0. Exception: JUMP on the trap path drives address `CSR_MTVEC`.

## Timing
- Reset values: all outputs 0; state IDLE; latches cleared.
- `hold_o`:
  - Combinational high in IDLE during the accept cycle.
  - High in every non-IDLE state, including JUMP.
  - Low in the cycle after JUMP.
- Trap entry: accept at cycle N; writes at N+1 through N+4; `jump_o` at N+5; IDLE at N+6.
- mret: accept at N; mstatus write at N+1; `jump_o` at N+2.
- CSR outputs are decoded from the state register (Moore).
  - The only combinational path is `trap_csr_rdata_i` → wdata / `jump_addr_o`.
- The csr block gives idex writes priority over trap writes, so the pipeline must issue no idex CSR write while `hold_o` = 1. trap_ctrl does not detect or retry a collision.
- Simultaneous exception and interrupt: the exception is taken. The level interrupt is not consumed and is not latched.
- `mret_i` together with an exception on the same instruction: the exception is taken.
- Reset mid-sequence: return immediately to IDLE with outputs 0. CSRs already written are not rolled back.

## Configuration
- `TRAP_MTVAL_EN`:
  - Defined: W_MTVAL is present and trap entry takes 6 cycles to `jump_o` (N+5).
  - Undefined: W_MTVAL is removed, W_MCAUSE goes straight to W_MSTATUS, no mtval write ever occurs, and `jump_o` comes at N+4.

## Structure
- Shared defines: `CSR_MSTATUS` / `CSR_MTVEC` / `CSR_MEPC` / `CSR_MCAUSE` / `CSR_MTVAL`, the mcause code constants, the state encoding, and the `TRAP_MTVAL_EN` macro.
- One sub-module, `trap_prio`: purely combinational priority encoder from the event inputs to {take, kind, mcause}. The FSM and latches stay in trap_ctrl.

## Test plan
- ecall at `inst_pc_i` = 0x100 with mtvec = 0x2001:
  - Writes mepc = 0x100, mcause = 11, mtval = 0.
  - mstatus MIE 1 → MPIE = 1, MIE = 0.
  - `jump_addr_o` = 0x2000 at N+5; `hold_o` spans N to N+5.
- Illegal instruction 0xFFFF_FFFF at 0x40: mcause = 2, mtval = 0xFFFF_FFFF, mepc = 0x40.
- `ex_trap_valid_i` and `tcmp_trap_valid_i` both high, MIE = 1, `next_pc_i` = 0x84: mcause = 0x8000_000B, mepc = 0x84.
- Any interrupt with MIE = 0: no hold and no writes. Interrupt together with ebreak: mcause = 3.
- mret with mstatus MPIE = 1, `mepc_i` = 0x84:
  - Writes MIE = 1, MPIE = 1.
  - `jump_o` at N+2, target 0x84.
- `rst_n` low at W_MCAUSE: all outputs 0 immediately; the next accepted trap restarts at W_MEPC.
- `TRAP_MTVAL_EN` undefined: no write to `CSR_MTVAL`; `jump_o` at N+4.
